// File: rtl/iob_gpio_pulse_gen.sv
// Programmable pulse-train generator for a GPIO output pad: high/low phase
// lengths, repeat count and idle level are captured on start.
module iob_gpio_pulse_gen #(
   parameter int CNT_W = 16,
   parameter int REP_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] high_cnt,
   input  logic [CNT_W-1:0] low_cnt,
   input  logic [REP_W-1:0] rep_cnt,
   input  logic             idle_level,
   output logic             out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t           state, state_n;
   logic             out_n, busy_n, done_n;
   logic [CNT_W-1:0] phase_cnt, phase_cnt_n;
   logic [REP_W-1:0] pulses_rem, pulses_rem_n;
   logic [CNT_W-1:0] high_q, high_n;
   logic [CNT_W-1:0] low_q, low_n;
   logic [REP_W-1:0] rep_q, rep_n;
   logic             idle_q, idle_n;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         out        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         phase_cnt  <= '0;
         pulses_rem <= '0;
         high_q     <= '0;
         low_q      <= '0;
         rep_q      <= '0;
         idle_q     <= 1'b0;
      end else begin
         state      <= state_n;
         out        <= out_n;
         busy       <= busy_n;
         done       <= done_n;
         phase_cnt  <= phase_cnt_n;
         pulses_rem <= pulses_rem_n;
         high_q     <= high_n;
         low_q      <= low_n;
         rep_q      <= rep_n;
         idle_q     <= idle_n;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave a signal unassigned and infer a latch.
      state_n      = state;
      out_n        = out;
      busy_n       = busy;
      done_n       = 1'b0;
      phase_cnt_n  = phase_cnt;
      pulses_rem_n = pulses_rem;
      high_n       = high_q;
      low_n        = low_q;
      rep_n        = rep_q;
      idle_n       = idle_q;

      unique case (state)
         IDLE: begin
            out_n  = idle_level;
            busy_n = 1'b0;
            if (start && !abort) begin
               high_n = high_cnt;
               low_n  = low_cnt;
               rep_n  = rep_cnt;
               idle_n = idle_level;
               if (high_cnt == '0 || rep_cnt == '0) begin
                  done_n = 1'b1;
               end else begin
                  state_n      = HIGH;
                  out_n        = ~idle_level;
                  busy_n       = 1'b1;
                  phase_cnt_n  = high_cnt - CNT_W'(1);
                  pulses_rem_n = rep_cnt - REP_W'(1);
               end
            end
         end

         HIGH: begin
            if (abort) begin
               state_n = IDLE;
               out_n   = idle_q;
               busy_n  = 1'b0;
            end else if (phase_cnt != '0) begin
               phase_cnt_n = phase_cnt - CNT_W'(1);
            end else if (pulses_rem == '0) begin
               state_n = IDLE;
               out_n   = idle_q;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else if (low_q != '0) begin
               state_n     = LOW;
               out_n       = idle_q;
               phase_cnt_n = low_q - CNT_W'(1);
            end else begin
               // Zero gap: back-to-back pulses merge into one continuous level.
               phase_cnt_n  = high_q - CNT_W'(1);
               pulses_rem_n = pulses_rem - REP_W'(1);
            end
         end

         LOW: begin
            if (abort) begin
               state_n = IDLE;
               out_n   = idle_q;
               busy_n  = 1'b0;
            end else if (phase_cnt != '0) begin
               phase_cnt_n = phase_cnt - CNT_W'(1);
            end else begin
               state_n      = HIGH;
               out_n        = ~idle_q;
               phase_cnt_n  = high_q - CNT_W'(1);
               pulses_rem_n = pulses_rem - REP_W'(1);
            end
         end

         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_iob_gpio_pulse_gen.sv
// Scoreboard bench for iob_gpio_pulse_gen: expected per-cycle {out,busy,done}
// tuples are queued at launch and popped one per clock.
module tb_iob_gpio_pulse_gen;

   localparam int CNT_W = 16;
   localparam int REP_W = 8;

   typedef struct packed {
      logic out;
      logic busy;
      logic done;
   } exp_t;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] low_cnt;
   logic [REP_W-1:0] rep_cnt;
   logic             idle_level;
   logic             out;
   logic             busy;
   logic             done;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   iob_gpio_pulse_gen #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .high_cnt   (high_cnt),
      .low_cnt    (low_cnt),
      .rep_cnt    (rep_cnt),
      .idle_level (idle_level),
      .out        (out),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected waveform of a normal train, one entry per cycle after the start edge.
   task automatic push_train(input logic idl, input int h, input int l, input int r);
      if (h == 0 || r == 0) begin
         sb_q.push_back('{out: idl, busy: 1'b0, done: 1'b1});
      end else begin
         for (int p = 0; p < r; p++) begin
            for (int c = 0; c < h; c++) sb_q.push_back('{out: ~idl, busy: 1'b1, done: 1'b0});
            if (p != r - 1)
               for (int c = 0; c < l; c++) sb_q.push_back('{out: idl, busy: 1'b1, done: 1'b0});
         end
         sb_q.push_back('{out: idl, busy: 1'b0, done: 1'b1});
      end
      sb_q.push_back('{out: idl, busy: 1'b0, done: 1'b0});
      sb_q.push_back('{out: idl, busy: 1'b0, done: 1'b0});
   endtask

   // Launch a train and drain the scoreboard. hook_kind: 0 none,
   // 1 abort+start in cycle hook_at, 2 start with new config while busy.
   task automatic launch(input string tag, input logic idl, input int h, input int l,
                         input int r, input int hook_at, input int hook_kind);
      exp_t e;
      int   cyc;
      @(negedge clk);
      idle_level = idl;
      high_cnt   = CNT_W'(h);
      low_cnt    = CNT_W'(l);
      rep_cnt    = REP_W'(r);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc   = 1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check($sformatf("%s.c%0d", tag, cyc), {29'd0, out, busy, done}, {29'd0, e});
         if (cyc == hook_at && hook_kind == 1) begin
            abort      = 1'b1;
            start      = 1'b1;
            high_cnt   = CNT_W'(2);
            rep_cnt    = REP_W'(1);
         end else if (cyc == hook_at && hook_kind == 2) begin
            start      = 1'b1;
            high_cnt   = CNT_W'(1);
            low_cnt    = CNT_W'(0);
            rep_cnt    = REP_W'(1);
            idle_level = ~idl;
         end
         @(posedge clk);
         #1;
         abort      = 1'b0;
         start      = 1'b0;
         idle_level = idl;
         cyc++;
      end
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      high_cnt   = '0;
      low_cnt    = '0;
      rep_cnt    = '0;
      idle_level = 1'b1;

      // Reset state, then idle level appears one cycle after release.
      repeat (2) @(posedge clk);
      #1;
      check("rst.out", {31'd0, out}, 32'd0);
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel.out", {31'd0, out}, 32'd1);
      check("rel.busy", {31'd0, busy}, 32'd0);
      check("rel.done", {31'd0, done}, 32'd0);

      // Basic two-pulse train.
      push_train(1'b0, 3, 2, 2);
      launch("t322", 1'b0, 3, 2, 2, 0, 0);

      // Zero gap gives one continuous active stretch of 12 cycles.
      push_train(1'b1, 4, 0, 3);
      launch("t403", 1'b1, 4, 0, 3, 0, 0);

      // Degenerate configurations complete immediately.
      push_train(1'b0, 0, 3, 5);
      launch("h0", 1'b0, 0, 3, 5, 0, 0);
      push_train(1'b1, 5, 3, 0);
      launch("r0", 1'b1, 5, 3, 0, 0, 0);

      // Abort in cycle 4 with a simultaneous start; start must be dropped.
      for (int c = 0; c < 4; c++) sb_q.push_back('{out: 1'b1, busy: 1'b1, done: 1'b0});
      for (int c = 0; c < 3; c++) sb_q.push_back('{out: 1'b0, busy: 1'b0, done: 1'b0});
      launch("abort", 1'b0, 10, 0, 1, 4, 1);

      // Start with new config and a flipped idle input while busy is ignored.
      push_train(1'b0, 2, 1, 2);
      launch("busy_start", 1'b0, 2, 1, 2, 2, 2);

      // Asynchronous reset mid-HIGH.
      @(negedge clk);
      idle_level = 1'b0;
      high_cnt   = CNT_W'(10);
      low_cnt    = CNT_W'(0);
      rep_cnt    = REP_W'(1);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      check("mid.out", {31'd0, out}, 32'd1);
      check("mid.busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst.out", {31'd0, out}, 32'd0);
      check("arst.busy", {31'd0, busy}, 32'd0);
      check("arst.done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post.out", {31'd0, out}, 32'd0);
      check("post.busy", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("post.stay", {30'd0, out, busy}, 32'd0);

      // Still fully functional after the mid-train reset.
      push_train(1'b1, 1, 1, 2);
      launch("after_rst", 1'b1, 1, 1, 2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
